// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
// Frame is NUM_SLOTS words; the FSM idles until a start-of-frame word.
package tdm_pkg;

    localparam int NUM_SLOTS = 4;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

endpackage

// File: rtl/tdm_gap_timer.sv
// Saturating idle-cycle counter used to time out stalled frames.
// expired flags the inc cycle that brings the count to GAP_MAX.
module tdm_gap_timer #(
    parameter int GAP_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int CW = $clog2(GAP_MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && cnt_q != CW'(GAP_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = inc && (cnt_q >= CW'(GAP_MAX - 1));

endmodule

// File: rtl/tdm_demux.sv
// Serial-to-parallel TDM demultiplexer: four slot words per frame.
// A frame is published to chA..chD only when all four slots arrive.
module tdm_demux
    import tdm_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int GAP_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] chA,
    output logic [WIDTH-1:0] chB,
    output logic [WIDTH-1:0] chC,
    output logic [WIDTH-1:0] chD,
    output logic             out_valid,
    output logic             frame_err,
    output logic [1:0]       slot
);

    localparam logic [1:0] LAST = 2'(NUM_SLOTS - 1);

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [NUM_SLOTS];
    logic [WIDTH-1:0] shadow_d [NUM_SLOTS];
    logic [WIDTH-1:0] ch_q [NUM_SLOTS];
    logic [WIDTH-1:0] ch_d [NUM_SLOTS];
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             gap_clear, gap_inc, gap_expired;

    tdm_gap_timer #(
        .GAP_MAX(GAP_MAX)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .clear  (gap_clear),
        .inc    (gap_inc),
        .expired(gap_expired)
    );

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        shadow_d    = shadow_q;
        ch_d        = ch_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
        gap_clear   = 1'b1;
        gap_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (din_valid && sof) begin
                    shadow_d[0] = din;
                    slot_d      = 2'd1;
                    state_d     = COLLECT;
                end
            end
            COLLECT: begin
                gap_clear = din_valid;
                gap_inc   = !din_valid;
                // A new sof always wins, even over a slot-3 completion
                if (din_valid && sof) begin
                    frame_err_d = 1'b1;
                    shadow_d[0] = din;
                    slot_d      = 2'd1;
                end else if (din_valid) begin
                    shadow_d[slot_q] = din;
                    if (slot_q == LAST) begin
                        ch_d        = shadow_d;
                        out_valid_d = 1'b1;
                        slot_d      = 2'd0;
                        state_d     = IDLE;
                    end else begin
                        slot_d = slot_q + 2'd1;
                    end
                end else if (gap_expired) begin
                    frame_err_d = 1'b1;
                    slot_d      = 2'd0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            slot_q      <= 2'd0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                shadow_q[i] <= '0;
                ch_q[i]     <= '0;
            end
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            shadow_q    <= shadow_d;
            ch_q        <= ch_d;
        end
    end

    assign chA       = ch_q[0];
    assign chB       = ch_q[1];
    assign chC       = ch_q[2];
    assign chD       = ch_q[3];
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign slot      = slot_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: directed frames plus random traffic
// compared every cycle against a queue-based frame model.
module tb_tdm_demux;

    localparam int WIDTH   = 2;
    localparam int GAP_MAX = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] chA, chB, chC, chD;
    logic             out_valid, frame_err;
    logic [1:0]       slot;

    int vectors = 0;
    int misses  = 0;
    bit chk_en  = 1'b0;

    tdm_demux #(
        .WIDTH  (WIDTH),
        .GAP_MAX(GAP_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_valid(din_valid),
        .sof      (sof),
        .chA      (chA),
        .chB      (chB),
        .chC      (chC),
        .chD      (chD),
        .out_valid(out_valid),
        .frame_err(frame_err),
        .slot     (slot)
    );

    always #5 clk = ~clk;

    // Frame model: words of the open frame sit in a queue
    int exp_ch[4];
    bit exp_ov, exp_fe;
    int exp_slot;
    int fq[$];
    int gap;
    bit open_frame;

    always @(posedge clk) begin
        exp_ov = 1'b0;
        exp_fe = 1'b0;
        if (rst) begin
            foreach (exp_ch[i]) exp_ch[i] = 0;
            fq.delete();
            gap = 0;
            open_frame = 1'b0;
        end else if (!open_frame) begin
            if (din_valid && sof) begin
                fq = {int'(din)};
                open_frame = 1'b1;
                gap = 0;
            end
        end else if (din_valid && sof) begin
            exp_fe = 1'b1;
            fq = {int'(din)};
            gap = 0;
        end else if (din_valid) begin
            fq.push_back(int'(din));
            gap = 0;
            if (fq.size() == 4) begin
                for (int i = 0; i < 4; i++) exp_ch[i] = fq[i];
                exp_ov = 1'b1;
                fq.delete();
                open_frame = 1'b0;
            end
        end else begin
            gap++;
            if (gap >= GAP_MAX) begin
                exp_fe = 1'b1;
                fq.delete();
                open_frame = 1'b0;
                gap = 0;
            end
        end
        exp_slot = fq.size();
    end

    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            misses++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_chA", int'(chA), exp_ch[0]);
            check("m_chB", int'(chB), exp_ch[1]);
            check("m_chC", int'(chC), exp_ch[2]);
            check("m_chD", int'(chD), exp_ch[3]);
            check("m_out_valid", int'(out_valid), int'(exp_ov));
            check("m_frame_err", int'(frame_err), int'(exp_fe));
            check("m_slot", int'(slot), exp_slot);
        end
    end

    task automatic cyc(input bit r, input bit v, input bit s, input int d);
        rst       = r;
        din_valid = v;
        sof       = s;
        din       = WIDTH'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ch(input string nm, input int a, input int b,
                          input int c, input int d);
        check({nm, "_chA"}, int'(chA), a);
        check({nm, "_chB"}, int'(chB), b);
        check({nm, "_chC"}, int'(chC), c);
        check({nm, "_chD"}, int'(chD), d);
    endtask

    bit fe_seen;

    initial begin
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 3);
        chk_en = 1'b1;
        chk_ch("reset", 0, 0, 0, 0);
        check("reset_ov", int'(out_valid), 0);
        check("reset_fe", int'(frame_err), 0);
        check("reset_slot", int'(slot), 0);

        // Clean frame
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 2);
        cyc(0, 1, 0, 3);
        check("clean_ov_early", int'(out_valid), 0);
        cyc(0, 1, 0, 0);
        check("clean_ov", int'(out_valid), 1);
        chk_ch("clean", 1, 2, 3, 0);
        check("model_chA", exp_ch[0], 1);
        check("model_chC", exp_ch[2], 3);
        cyc(0, 0, 0, 0);
        check("clean_ov_once", int'(out_valid), 0);

        // Gapped frame
        fe_seen = 1'b0;
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 2);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            fe_seen |= frame_err;
        end
        cyc(0, 1, 0, 3);
        fe_seen |= frame_err;
        cyc(0, 1, 0, 0);
        fe_seen |= frame_err;
        check("gap_ov", int'(out_valid), 1);
        check("gap_no_fe", int'(fe_seen), 0);
        chk_ch("gap", 1, 2, 3, 0);

        // Early sof
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 2);
        cyc(0, 1, 1, 3);
        check("early_fe", int'(frame_err), 1);
        check("early_slot", int'(slot), 1);
        chk_ch("early_hold", 1, 2, 3, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 2);
        check("early_ov", int'(out_valid), 1);
        chk_ch("early", 3, 0, 1, 2);
        check("model_early_chA", exp_ch[0], 3);

        // Timeout
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 2);
        for (int i = 0; i < GAP_MAX - 1; i++) cyc(0, 0, 0, 0);
        check("to_fe_early", int'(frame_err), 0);
        check("to_slot_hold", int'(slot), 2);
        cyc(0, 0, 0, 0);
        check("to_fe", int'(frame_err), 1);
        check("to_slot", int'(slot), 0);
        chk_ch("to_hold", 3, 0, 1, 2);
        cyc(0, 0, 0, 0);
        check("to_fe_once", int'(frame_err), 0);

        // Reset mid-frame
        cyc(0, 1, 1, 1);
        cyc(0, 1, 0, 2);
        cyc(1, 1, 0, 3);
        chk_ch("rst_mid", 0, 0, 0, 0);
        check("rst_mid_slot", int'(slot), 0);
        check("rst_mid_fe", int'(frame_err), 0);
        cyc(0, 1, 1, 2);
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 3);
        check("rst_next_ov", int'(out_valid), 1);
        chk_ch("rst_next", 2, 1, 0, 3);

        // Stray words in IDLE
        cyc(0, 1, 0, 1);
        cyc(0, 1, 0, 2);
        check("stray_ov", int'(out_valid), 0);
        check("stray_fe", int'(frame_err), 0);
        check("stray_slot", int'(slot), 0);
        chk_ch("stray", 2, 1, 0, 3);

        // Random traffic: busy phases and sparse phases to hit timeouts
        for (int p = 0; p < 12; p++) begin
            int vpct;
            vpct = (p % 3 == 2) ? 4 : 80;
            for (int i = 0; i < 300; i++) begin
                cyc($urandom_range(199) == 0,
                    $urandom_range(99) < vpct,
                    $urandom_range(99) < 12,
                    int'($urandom_range(3)));
            end
        end

        cyc(0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
